// File: rtl/fft32_pkg.sv
// fft32_pkg: shared constants, types and address helpers for the 32-point FFT sequencer
package fft32_pkg;
  localparam int N = 32;
  localparam int LOG2N = 5;
  localparam int BFLY_PER_STAGE = 16;
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} seq_state_t;
  typedef logic [4:0] addr_t;
  typedef logic [3:0] tw_t;
  function automatic addr_t bitrev5(addr_t x);
    return {x[0], x[1], x[2], x[3], x[4]};
  endfunction
  function automatic addr_t bf_half(logic [2:0] s);
    return addr_t'(1) << s;
  endfunction
  // a = grp*2*half + pos, with grp = k>>s and pos = k & (half-1)
  function automatic addr_t bf_addr_a(logic [2:0] s, logic [3:0] k);
    addr_t kk = {1'b0, k};
    return ((kk >> s) << (s + 3'd1)) | (kk & (bf_half(s) - 5'd1));
  endfunction
  function automatic addr_t bf_addr_b(logic [2:0] s, logic [3:0] k);
    return bf_addr_a(s, k) + bf_half(s);
  endfunction
  function automatic tw_t bf_tw(logic [2:0] s, logic [3:0] k);
    addr_t kk = {1'b0, k};
    return tw_t'((kk & (bf_half(s) - 5'd1)) << (3'd4 - s));
  endfunction
endpackage

// File: rtl/fft32_stage_sequencer_if.sv
// fft32_stage_sequencer_if: frame/butterfly/result handshake bundle
// master = sequencer (drives control outputs), slave = datapath/consumer side.
interface fft32_stage_sequencer_if;
  import fft32_pkg::*;
  logic frame_valid;
  logic frame_ready;
  logic load_en;
  logic bf_valid;
  addr_t rd_addr_a;
  addr_t rd_addr_b;
  tw_t tw_idx;
  logic [2:0] stage;
  logic wr_en;
  addr_t wr_addr_a;
  addr_t wr_addr_b;
  logic scale;
  logic res_valid;
  logic res_ready;
  logic busy;
  modport master (
    input frame_valid, res_ready,
    output frame_ready, load_en, bf_valid, rd_addr_a, rd_addr_b, tw_idx, stage,
    wr_en, wr_addr_a, wr_addr_b, scale, res_valid, busy
  );
  modport slave (
    output frame_valid, res_ready,
    input frame_ready, load_en, bf_valid, rd_addr_a, rd_addr_b, tw_idx, stage,
    wr_en, wr_addr_a, wr_addr_b, scale, res_valid, busy
  );
endinterface

// File: rtl/fft32_wb_delay.sv
// fft32_wb_delay: BF_LAT-deep shift register carrying {valid, addr_a, addr_b}
// Ports: clk_100, reset (async active-low clear), in_* (issue side), out_* (write-back side).
module fft32_wb_delay
  import fft32_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic  clk_100,
  input  logic  reset,
  input  logic  in_valid,
  input  addr_t in_addr_a,
  input  addr_t in_addr_b,
  output logic  out_valid,
  output addr_t out_addr_a,
  output addr_t out_addr_b
);
  typedef struct packed {
    logic  v;
    addr_t a;
    addr_t b;
  } wb_t;
  wb_t sr [BF_LAT];
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) sr <= '{default: '0};
    else begin
      sr[0] <= {in_valid, in_addr_a, in_addr_b};
      for (int i = 1; i < BF_LAT; i++) sr[i] <= sr[i-1];
    end
  end
  assign {out_valid, out_addr_a, out_addr_b} = sr[BF_LAT-1];
endmodule

// File: rtl/fft32_stage_sequencer.sv
// fft32_stage_sequencer: schedules 5 stages x 16 radix-2 butterflies for a 32-point DIT FFT
// Ports: clk_100, reset (async active-low), sif (master modport: frame handshake,
// butterfly issue, delayed write-back, result handshake, busy).
// Option: FFT_SEQ_SCALE_EN drives scale with bf_valid; otherwise scale is 0.
module fft32_stage_sequencer
  import fft32_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input logic clk_100,
  input logic reset,
  fft32_stage_sequencer_if.master sif
);
  localparam logic [3:0] KLAST = 4'(BFLY_PER_STAGE - 1);
  localparam logic [2:0] SLAST = 3'(LOG2N - 1);
  localparam logic [2:0] DLAST = 3'(BF_LAT - 1);
  seq_state_t state;
  logic [2:0] s_q, nxt_s, dcnt;
  logic [3:0] k_q, nxt_k;
  logic issue, frame_ready, load_en, bf_valid, res_valid, busy;
  addr_t ra, rb;
  tw_t tw;
  // (nxt_s, nxt_k) is the butterfly issued on this edge when issue is high
  always_comb begin
    nxt_s = (state == DRAIN) ? s_q + 3'd1 : (state == RUN) ? s_q : 3'd0;
    nxt_k = (state == RUN) ? k_q + 4'd1 : 4'd0;
    issue = (state == LOAD) || (state == RUN && k_q != KLAST) ||
            (state == DRAIN && dcnt == DLAST && s_q != SLAST);
  end
  always_ff @(posedge clk_100 or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      s_q <= '0;
      k_q <= '0;
      dcnt <= '0;
      ra <= '0;
      rb <= '0;
      tw <= '0;
      frame_ready <= 1'b1;
      load_en <= 1'b0;
      bf_valid <= 1'b0;
      res_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      load_en <= state == IDLE && sif.frame_valid;
      bf_valid <= issue;
      if (issue) begin
        s_q <= nxt_s;
        k_q <= nxt_k;
        ra <= bf_addr_a(nxt_s, nxt_k);
        rb <= bf_addr_b(nxt_s, nxt_k);
        tw <= bf_tw(nxt_s, nxt_k);
      end
      unique case (state)
        IDLE: if (sif.frame_valid) begin
          state <= LOAD;
          frame_ready <= 1'b0;
          busy <= 1'b1;
        end
        LOAD: state <= RUN;
        RUN: if (k_q == KLAST) begin
          state <= DRAIN;
          dcnt <= '0;
        end
        // the drain lets the last write of this stage land before the next stage reads
        DRAIN: if (dcnt != DLAST) dcnt <= dcnt + 3'd1;
        else if (s_q != SLAST) state <= RUN;
        else begin
          state <= DONE;
          res_valid <= 1'b1;
        end
        DONE: if (sif.res_ready) begin
          state <= IDLE;
          res_valid <= 1'b0;
          busy <= 1'b0;
          frame_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  fft32_wb_delay #(.BF_LAT(BF_LAT)) u_wb (
    .clk_100(clk_100),
    .reset(reset),
    .in_valid(bf_valid),
    .in_addr_a(ra),
    .in_addr_b(rb),
    .out_valid(sif.wr_en),
    .out_addr_a(sif.wr_addr_a),
    .out_addr_b(sif.wr_addr_b)
  );
  assign sif.frame_ready = frame_ready;
  assign sif.load_en = load_en;
  assign sif.bf_valid = bf_valid;
  assign sif.rd_addr_a = ra;
  assign sif.rd_addr_b = rb;
  assign sif.tw_idx = tw;
  assign sif.stage = s_q;
  assign sif.res_valid = res_valid;
  assign sif.busy = busy;
`ifdef FFT_SEQ_SCALE_EN
  assign sif.scale = bf_valid;
`else
  assign sif.scale = 1'b0;
`endif
endmodule

// File: tb/tb_fft32_stage_sequencer.sv
// tb_fft32_stage_sequencer: random-stimulus bench for BF_LAT = 1, 2, 8 against a schedule model
module tb_fft32_stage_sequencer;
  logic clk_100 = 1'b0;
  logic reset = 1'b1;
  always #5 clk_100 = ~clk_100;
  fft32_stage_sequencer_if i1();
  fft32_stage_sequencer_if i2();
  fft32_stage_sequencer_if i8();
  fft32_stage_sequencer #(.BF_LAT(1)) u1 (.clk_100(clk_100), .reset(reset), .sif(i1));
  fft32_stage_sequencer #(.BF_LAT(2)) u2 (.clk_100(clk_100), .reset(reset), .sif(i2));
  fft32_stage_sequencer #(.BF_LAT(8)) u8 (.clk_100(clk_100), .reset(reset), .sif(i8));
  int n_cmp = 0;
  int n_bad = 0;
  int lat [3] = '{1, 2, 8};
  int d_done [3] = '{0, 0, 0};
  int r_rel [3] = '{0, 0, 0};
  int n_bv [3];
  int n_we [3];
  task automatic check(string tag, int got, int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // period p counts edges since the accepting edge; stage s owns 16+L periods from p=2
  function automatic bit issue_at(int l, int p, output int s, output int k);
    int per = 16 + l;
    int m = p - 2;
    s = 0;
    k = 0;
    if (p < 2 || m >= 5 * per) return 1'b0;
    s = m / per;
    k = m % per;
    return k < 16;
  endfunction
  function automatic void bfly(int s, int k, output int a, output int b, output int t);
    int half = 1 << s;
    a = (k / half) * 2 * half + k % half;
    b = a + half;
    t = (k % half) * (16 / half);
  endfunction
  task automatic chk_dut(int j, int p, logic fr, logic le, logic bv, logic [4:0] ra, logic [4:0] rb,
                         logic [3:0] tw, logic [2:0] st, logic we, logic [4:0] wa, logic [4:0] wb,
                         logic sc, logic rv, logic bz);
    int s, k, ws, wk, a, b, t;
    bit ev, ew, bz_e;
    string nm = $sformatf("L%0d_p%0d", lat[j], p);
    ev = issue_at(lat[j], p, s, k);
    ew = issue_at(lat[j], p - lat[j], ws, wk);
    bz_e = p >= 1 && p <= r_rel[j];
    check({nm, " load_en"}, int'(le), int'(p == 1));
    check({nm, " bf_valid"}, int'(bv), int'(ev));
    check({nm, " wr_en"}, int'(we), int'(ew));
    check({nm, " res_valid"}, int'(rv), int'(bz_e && p >= d_done[j]));
    check({nm, " busy"}, int'(bz), int'(bz_e));
    check({nm, " frame_ready"}, int'(fr), int'(!bz_e));
`ifdef FFT_SEQ_SCALE_EN
    check({nm, " scale"}, int'(sc), int'(ev));
`else
    check({nm, " scale"}, int'(sc), 0);
`endif
    if (ev) begin
      bfly(s, k, a, b, t);
      check({nm, " rd_addr_a"}, int'(ra), a);
      check({nm, " rd_addr_b"}, int'(rb), b);
      check({nm, " tw_idx"}, int'(tw), t);
      check({nm, " stage"}, int'(st), s);
      if (s == 0 && k == 5) begin
        check({nm, " s0k5_a"}, int'(ra), 10);
        check({nm, " s0k5_b"}, int'(rb), 11);
        check({nm, " s0k5_tw"}, int'(tw), 0);
      end
      if (s == 2 && k == 5) begin
        check({nm, " s2k5_a"}, int'(ra), 9);
        check({nm, " s2k5_b"}, int'(rb), 13);
        check({nm, " s2k5_tw"}, int'(tw), 4);
      end
      if (s == 4 && k == 15) begin
        check({nm, " s4k15_a"}, int'(ra), 15);
        check({nm, " s4k15_b"}, int'(rb), 31);
        check({nm, " s4k15_tw"}, int'(tw), 15);
      end
    end
    if (ew) begin
      bfly(ws, wk, a, b, t);
      check({nm, " wr_addr_a"}, int'(wa), a);
      check({nm, " wr_addr_b"}, int'(wb), b);
    end
    if (p == 0) begin
      check({nm, " rst_rd_addr_a"}, int'(ra), 0);
      check({nm, " rst_rd_addr_b"}, int'(rb), 0);
      check({nm, " rst_tw_idx"}, int'(tw), 0);
      check({nm, " rst_stage"}, int'(st), 0);
      check({nm, " rst_wr_addr_a"}, int'(wa), 0);
      check({nm, " rst_wr_addr_b"}, int'(wb), 0);
    end
    n_bv[j] += int'(bv);
    n_we[j] += int'(we);
  endtask
  task automatic chk_all(int p);
    chk_dut(0, p, i1.frame_ready, i1.load_en, i1.bf_valid, i1.rd_addr_a, i1.rd_addr_b, i1.tw_idx,
            i1.stage, i1.wr_en, i1.wr_addr_a, i1.wr_addr_b, i1.scale, i1.res_valid, i1.busy);
    chk_dut(1, p, i2.frame_ready, i2.load_en, i2.bf_valid, i2.rd_addr_a, i2.rd_addr_b, i2.tw_idx,
            i2.stage, i2.wr_en, i2.wr_addr_a, i2.wr_addr_b, i2.scale, i2.res_valid, i2.busy);
    chk_dut(2, p, i8.frame_ready, i8.load_en, i8.bf_valid, i8.rd_addr_a, i8.rd_addr_b, i8.tw_idx,
            i8.stage, i8.wr_en, i8.wr_addr_a, i8.wr_addr_b, i8.scale, i8.res_valid, i8.busy);
  endtask
  task automatic drive(int j, logic fv, logic rr);
    if (j == 0) begin
      i1.frame_valid = fv;
      i1.res_ready = rr;
    end else if (j == 1) begin
      i2.frame_valid = fv;
      i2.res_ready = rr;
    end else begin
      i8.frame_valid = fv;
      i8.res_ready = rr;
    end
  endtask
  task automatic run_frame(int hold, bit abort);
    int maxp = 0;
    int rp [3];
    for (int j = 0; j < 3; j++) begin
      d_done[j] = 2 + 5 * (16 + lat[j]);
      r_rel[j] = d_done[j] + (hold >= 0 ? hold : int'($urandom_range(0, 20)));
      rp[j] = int'($urandom_range(2, r_rel[j] - 1));
      n_bv[j] = 0;
      n_we[j] = 0;
      if (r_rel[j] + 2 > maxp) maxp = r_rel[j] + 2;
    end
    @(negedge clk_100);
    for (int j = 0; j < 3; j++) drive(j, 1'b1, 1'b0);
    for (int p = 1; p <= maxp; p++) begin
      @(negedge clk_100);
      chk_all(p);
      if (abort && p == 30) begin
        #1 reset = 1'b0;
        #1 chk_all(0);
        for (int j = 0; j < 3; j++) begin
          drive(j, 1'b0, 1'b0);
          r_rel[j] = 0;
        end
        repeat (2) @(posedge clk_100);
        @(negedge clk_100) reset = 1'b1;
        repeat (12) begin
          @(negedge clk_100);
          chk_all(0);
        end
        break;
      end
      for (int j = 0; j < 3; j++)
        drive(j, p == 40 || p == rp[j] || p == r_rel[j],
              p == r_rel[j] || (p < d_done[j] && $urandom_range(0, 7) == 0));
    end
    if (!abort)
      for (int j = 0; j < 3; j++) begin
        check($sformatf("L%0d bf_valid_count", lat[j]), n_bv[j], 80);
        check($sformatf("L%0d wr_en_count", lat[j]), n_we[j], 80);
      end
  endtask
  initial begin
    for (int j = 0; j < 3; j++) drive(j, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 chk_all(0);
    repeat (2) @(posedge clk_100);
    @(negedge clk_100) reset = 1'b1;
    @(negedge clk_100);
    chk_all(0);
    run_frame(20, 1'b0);
    run_frame(0, 1'b1);
    run_frame(-1, 1'b0);
    run_frame(0, 1'b0);
    run_frame(-1, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
